// File: rtl/fadd_result_buffer.sv
// fadd_result_buffer
// Show-ahead result FIFO placed directly behind the fadd stage. It also tracks
// operations issued to fadd but not yet returned, and only grants issue_ok
// while every outstanding result is guaranteed a free slot.
// Sticky err_ovf / err_spur flags record dropped and unexpected results.
//
// Optional feature: define FADD_RESULT_NAN_FLAG_EN to store a per-entry NaN
// bit (presented as out_nan) and a saturating 16-bit pushed-NaN counter
// (nan_cnt). Without the macro, neither port nor the extra storage exists.
module fadd_result_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic             res_val,
    input  logic [WIDTH-1:0] res,
    output logic             issue_ok,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] inflight,
    output logic             err_ovf,
    output logic             err_spur,
    input  logic             err_clr
`ifdef FADD_RESULT_NAN_FLAG_EN
    ,
    output logic             out_nan,
    output logic [15:0]      nan_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    // count + inflight can reach 2*DEPTH, so the sum needs one extra bit
    localparam logic [CNT_W:0]   DEPTH_S = (CNT_W + 1)'(DEPTH);

`ifdef FADD_RESULT_NAN_FLAG_EN
    localparam int ENT_W = WIDTH + 1;
`else
    localparam int ENT_W = WIDTH;
`endif

    logic [ENT_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_spur_q, err_spur_d;

    logic             push;
    logic             pop;
    logic             inflight_inc;
    logic             inflight_dec;
    logic [CNT_W:0]   committed;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] rd_entry;

`ifdef FADD_RESULT_NAN_FLAG_EN
    logic             wr_nan;
    logic [15:0]      nan_cnt_q, nan_cnt_d;
`endif

    // Handshake decode, credit check and next-state for pointers, counters and flags.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        inflight_d   = inflight_q;

        // Credits come from registers only, so issue_ok never depends on same-cycle inputs
        committed    = {1'b0, count_q} + {1'b0, inflight_q};
        issue_ok     = (committed < DEPTH_S);

        pop          = (count_q != '0) && out_ready;
        // A pop frees the slot this cycle, so a full FIFO can still accept
        push         = res_val && ((count_q != DEPTH_C) || pop);

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);

        // Issues made while issue_ok is low are issuer errors and earn no credit
        inflight_inc = issue && issue_ok && (inflight_q != DEPTH_C);
        inflight_dec = res_val && (inflight_q != '0);
        if (inflight_inc && !inflight_dec)      inflight_d = inflight_q + CNT_W'(1);
        else if (!inflight_inc && inflight_dec) inflight_d = inflight_q - CNT_W'(1);

        // Set has priority over a same-cycle clear
        err_ovf_d    = (res_val && !push) || (err_ovf_q && !err_clr);
        err_spur_d   = (res_val && (inflight_q == '0)) || (err_spur_q && !err_clr);
    end

`ifdef FADD_RESULT_NAN_FLAG_EN
    // Classify the incoming result and advance the saturating NaN counter.
    always_comb begin
        wr_nan    = (res[30:23] == 8'hFF) && (res[22:0] != 23'd0);
        wr_entry  = {wr_nan, res};
        nan_cnt_d = err_clr ? 16'd0 : nan_cnt_q;
        if (push && wr_nan && (nan_cnt_d != 16'hFFFF)) nan_cnt_d = nan_cnt_d + 16'd1;
    end
`else
    // Entries hold the raw result only.
    always_comb begin
        wr_entry = res;
    end
`endif

    // Control state; async reset discards all buffered and in-flight bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            err_ovf_q  <= 1'b0;
            err_spur_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_ovf_q  <= err_ovf_d;
            err_spur_q <= err_spur_d;
        end
    end

`ifdef FADD_RESULT_NAN_FLAG_EN
    // NaN counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) nan_cnt_q <= 16'd0;
        else     nan_cnt_q <= nan_cnt_d;
    end
`endif

    // Storage write; the array is not reset, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_entry;
    end

    // Show-ahead read: the head entry is always driven; no same-cycle bypass.
    assign rd_entry  = mem[rd_ptr_q];
    assign out_data  = rd_entry[WIDTH-1:0];
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign inflight  = inflight_q;
    assign err_ovf   = err_ovf_q;
    assign err_spur  = err_spur_q;

`ifdef FADD_RESULT_NAN_FLAG_EN
    assign out_nan   = rd_entry[WIDTH];
    assign nan_cnt   = nan_cnt_q;
`endif

endmodule

// File: tb/tb_fadd_result_buffer.sv
// Testbench for fadd_result_buffer: directed scenarios plus a randomized phase.
// A queue-based reference model runs on the clock; a separate monitor pops the
// expected queue on each consumer handshake and compares all outputs.
module tb_fadd_result_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue;
    logic             res_val;
    logic [WIDTH-1:0] res;
    logic             issue_ok;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] inflight;
    logic             err_ovf;
    logic             err_spur;
    logic             err_clr;
`ifdef FADD_RESULT_NAN_FLAG_EN
    logic             out_nan;
    logic [15:0]      nan_cnt;
`endif

    fadd_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .res_val   (res_val),
        .res       (res),
        .issue_ok  (issue_ok),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .inflight  (inflight),
        .err_ovf   (err_ovf),
        .err_spur  (err_spur),
        .err_clr   (err_clr)
`ifdef FADD_RESULT_NAN_FLAG_EN
        ,
        .out_nan   (out_nan),
        .nan_cnt   (nan_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    // Reference model state
    logic [31:0] exp_q[$];
    int m_count    = 0;
    int m_inflight = 0;
    int m_ovf      = 0;
    int m_spur     = 0;
    int m_nan_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] d);
        return (d[30:23] == 8'hFF) && (d[22:0] != 23'd0);
    endfunction

    // Reference model step, evaluated from the inputs present at the clock edge.
    task automatic model_step();
        bit ok, pop_m, push_m, inc, dec;
        if (rst) begin
            m_count = 0; m_inflight = 0; m_ovf = 0; m_spur = 0; m_nan_cnt = 0;
            exp_q.delete();
            return;
        end
        ok     = (m_count + m_inflight) < DEPTH;
        pop_m  = (m_count > 0) && out_ready;
        push_m = res_val && ((m_count < DEPTH) || pop_m);
        inc    = issue && ok;
        dec    = res_val && (m_inflight > 0);
        m_spur = (res_val && (m_inflight == 0)) ? 1 : (err_clr ? 0 : m_spur);
        m_ovf  = (res_val && !push_m) ? 1 : (err_clr ? 0 : m_ovf);
        m_inflight = m_inflight + int'(inc) - int'(dec);
        if (push_m) exp_q.push_back(res);
        m_count = m_count + int'(push_m) - int'(pop_m);
        if (err_clr) m_nan_cnt = 0;
        if (push_m && is_nan(res) && (m_nan_cnt < 65535)) m_nan_cnt++;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    // Monitor: compare state every cycle, pop the scoreboard on each handshake.
    initial begin
        logic [31:0] e;
        bit          hold;
        logic [31:0] hold_d;
        hold   = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("count",     32'(count),     32'(m_count));
                chk("inflight",  32'(inflight),  32'(m_inflight));
                chk("issue_ok",  32'(issue_ok),  32'((m_count + m_inflight) < DEPTH));
                chk("out_valid", 32'(out_valid), 32'(m_count != 0));
                chk("err_ovf",   32'(err_ovf),   32'(m_ovf));
                chk("err_spur",  32'(err_spur),  32'(m_spur));
`ifdef FADD_RESULT_NAN_FLAG_EN
                chk("nan_cnt",   32'(nan_cnt),   32'(m_nan_cnt));
`endif
                if (hold && out_valid) chk("hold_data", out_data, hold_d);
                hold   = out_valid && !out_ready;
                hold_d = out_data;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_pop: got pop of %h want no entry", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e);
`ifdef FADD_RESULT_NAN_FLAG_EN
                        chk("out_nan", 32'(out_nan), 32'(is_nan(e)));
`endif
                    end
                end
            end
        end
    end

    // Drive one cycle of inputs, then advance to just after the next rising edge.
    task automatic cyc(input logic i, input logic v, input logic [31:0] d,
                       input logic r, input logic c);
        issue = i; res_val = v; res = d; out_ready = r; err_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rv;
        rst = 1'b1; issue = 0; res_val = 0; res = '0; out_ready = 0; err_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        chk("rst_count",    32'(count),     32'd0);
        chk("rst_inflight", 32'(inflight),  32'd0);
        chk("rst_issue_ok", 32'(issue_ok),  32'd1);
        chk("rst_valid",    32'(out_valid), 32'd0);
        chk("rst_errs",     32'({err_ovf, err_spur}), 32'd0);

        // Three issues, three results held, then released in order
        repeat (3) cyc(1, 0, 32'h0, 0, 0);
        cyc(0, 1, 32'h3F800000, 0, 0);
        cyc(0, 1, 32'h40000000, 0, 0);
        cyc(0, 1, 32'h40400000, 0, 0);
        chk("p1_count",    32'(count),    32'd3);
        chk("p1_inflight", 32'(inflight), 32'd0);
        chk("p1_head",     out_data,      32'h3F800000);
        cyc(0, 0, 32'h0, 1, 0);
        chk("p1_head2",    out_data,      32'h40000000);
        repeat (2) cyc(0, 0, 32'h0, 1, 0);
        chk("p1_empty",    32'(out_valid), 32'd0);

        // Credit exhaustion by in-flight operations
        repeat (8) cyc(1, 0, 32'h0, 0, 0);
        chk("p2_ok_lo",    32'(issue_ok), 32'd0);
        cyc(0, 1, 32'h11111111, 0, 0);
        chk("p2_inflight", 32'(inflight), 32'd7);
        chk("p2_count",    32'(count),    32'd1);
        chk("p2_ok_still", 32'(issue_ok), 32'd0);
        cyc(0, 0, 32'h0, 1, 0);
        chk("p2_ok_hi",    32'(issue_ok), 32'd1);
        for (int i = 0; i < 7; i++) cyc(0, 1, $urandom, 1, 0);
        cyc(0, 0, 32'h0, 1, 0);

        // Full FIFO: dropped push, then push with simultaneous pop
        repeat (8) cyc(1, 0, 32'h0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 32'h1000 + 32'(i), 0, 0);
        chk("p3_full",     32'(count), 32'd8);
        cyc(0, 1, 32'hDEADBEEF, 0, 0);
        chk("p3_ovf",      32'(err_ovf), 32'd1);
        chk("p3_cnt_hold", 32'(count),   32'd8);
        chk("p3_head",     out_data,     32'h1000);
        cyc(0, 0, 32'h0, 0, 1);
        chk("p3_clr",      32'({err_ovf, err_spur}), 32'd0);
        cyc(0, 1, 32'hDEADBEEF, 1, 0);
        chk("p3_no_ovf",   32'(err_ovf), 32'd0);
        chk("p3_cnt_8",    32'(count),   32'd8);
        chk("p3_head2",    out_data,     32'h1001);
        repeat (7) cyc(0, 0, 32'h0, 1, 0);
        chk("p3_tail",     out_data,     32'hDEADBEEF);
        cyc(0, 0, 32'h0, 1, 1);

        // Spurious completions and clear/set priority
        cyc(0, 1, 32'h12345678, 0, 0);
        chk("p4_spur",     32'(err_spur), 32'd1);
        chk("p4_pushed",   32'(count),    32'd1);
        cyc(0, 0, 32'h0, 0, 1);
        chk("p4_clr",      32'(err_spur), 32'd0);
        cyc(0, 1, 32'h0BADF00D, 0, 1);
        chk("p4_set_wins", 32'(err_spur), 32'd1);
        repeat (2) cyc(0, 0, 32'h0, 1, 1);
        chk("p4_cleared",  32'(err_spur), 32'd0);

        // Stream 20 results with out_ready toggling, wrapping both pointers
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 32'h0, 1, 0);
            cyc(0, 1, 32'h2000 + 32'(i), 0, 0);
        end
        repeat (4) cyc(0, 0, 32'h0, 1, 0);
        chk("p5_drained",  32'(count),   32'd0);
        chk("p5_no_ovf",   32'(err_ovf), 32'd0);

        // Randomized traffic with occasional mid-stream resets
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       rv = 32'h7FC00000 | 32'($urandom_range(0, 255));
                1:       rv = 32'h7F800000;
                default: rv = $urandom;
            endcase
            if ($urandom_range(0, 99) == 0) rst = 1'b1;
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rv,
                1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
            rst = 1'b0;
        end
        repeat (10) cyc(0, 0, 32'h0, 1, 1);

`ifdef FADD_RESULT_NAN_FLAG_EN
        // NaN classification and counting
        cyc(0, 0, 32'h0, 0, 1);
        cyc(0, 1, 32'h7FC00000, 0, 0);
        cyc(0, 1, 32'h7F800000, 0, 0);
        cyc(0, 1, 32'h00000000, 0, 0);
        chk("nan_cnt1",    32'(nan_cnt), 32'd1);
        chk("nan_head",    32'(out_nan), 32'd1);
        cyc(0, 0, 32'h0, 1, 0);
        chk("nan_inf",     32'(out_nan), 32'd0);
`endif

        // Asynchronous reset in the middle of buffered traffic
        cyc(0, 1, 32'hCAFE0001, 0, 0);
        cyc(0, 1, 32'hCAFE0002, 0, 0);
        rst = 1'b1;
        #1;
        chk("mrst_count",  32'(count),     32'd0);
        chk("mrst_valid",  32'(out_valid), 32'd0);
`ifdef FADD_RESULT_NAN_FLAG_EN
        chk("mrst_nan",    32'(nan_cnt),   32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 1, 32'hCAFE0003, 0, 0);
        chk("post_spur",   32'(err_spur), 32'd1);
        repeat (3) cyc(0, 0, 32'h0, 1, 1);
        chk("final_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
